// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one iterative 8x8 multiplier among NUM_REQ clients.
// Define MUL_TIMEOUT_EN to bound the wait for mul_done (TIMEOUT cycles).
module mul_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 63
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic                 mul_start,
  output logic [7:0]           mul_a,
  output logic [7:0]           mul_b,
  input  logic                 mul_done,
  input  logic [15:0]          mul_p,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [15:0]          resp_p,
  output logic                 resp_err,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [7:0]        mul_a_q, mul_a_d;
  logic [7:0]        mul_b_q, mul_b_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  logic [15:0]       resp_p_q, resp_p_d;
  logic              resp_err_q, resp_err_d;

  logic              win_vld;
  logic [ID_W-1:0]   win_id;
  logic [NUM_REQ-1:0] grant;
  int                idx;

`ifdef MUL_TIMEOUT_EN
  localparam int CNT_W =
    ($clog2(TIMEOUT + 1) < 6) ? 6 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

  // Scan downward so the nearest set bit after ptr is the last to win.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    resp_id_d  = resp_id_q;
    resp_p_d   = resp_p_q;
    resp_err_d = resp_err_q;
    grant      = '0;
`ifdef MUL_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          grant[win_id] = 1'b1;
          mul_a_d       = req_a[8*int'(win_id) +: 8];
          mul_b_d       = req_b[8*int'(win_id) +: 8];
          resp_id_d     = win_id;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef MUL_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (mul_done) begin
          resp_p_d   = mul_p;
          resp_err_d = 1'b0;
          state_d    = S_RESP;
`ifdef MUL_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          resp_p_d   = 16'h0000;
          resp_err_d = 1'b1;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          ptr_d   = resp_id_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= ID_W'(NUM_REQ - 1);
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      resp_id_q  <= '0;
      resp_p_q   <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      resp_id_q  <= resp_id_d;
      resp_p_q   <= resp_p_d;
      resp_err_q <= resp_err_d;
    end
  end

`ifdef MUL_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
  assign resp_err = resp_err_q;
`else
  assign resp_err = 1'b0;
`endif

  // Grant is combinational, so hold it low while reset is asserted.
  assign req_ready  = grant & {NUM_REQ{~reset}};
  assign mul_start  = (state_q == S_ISSUE);
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign resp_valid = (state_q == S_RESP);
  assign resp_id    = resp_id_q;
  assign resp_p     = resp_p_q;
  assign busy       = (state_q != S_IDLE);

endmodule
